// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (LSL / LSR / ASR / ROR) with valid/ready handshake.
// Stage i shifts by 2^i when amount bit i is set; the last stage register drives out_*.
module shift_pipe #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_shout
);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    // One shift step by n; returns {bits_lost, shifted_data}.
    function automatic logic [WIDTH:0] stage_op(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             en,
        input int unsigned      n
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] lo_mask;
        logic [WIDTH-1:0] hi_mask;
        logic [WIDTH-1:0] r;
        logic             lost;
        ones    = '1;
        lo_mask = ~(ones << n);
        hi_mask = ~(ones >> n);
        r       = d;
        lost    = 1'b0;
        if (en) begin
            case (mode_e'(mode))
                MODE_LSL: begin
                    r    = d << n;
                    lost = |(d & hi_mask);
                end
                MODE_LSR: begin
                    r    = d >> n;
                    lost = |(d & lo_mask);
                end
                MODE_ASR: begin
                    // MSB is still the original sign bit at every stage
                    r    = $signed(d) >>> n;
                    lost = |(d & lo_mask);
                end
                MODE_ROR: begin
                    r    = (d >> n) | (d << (WIDTH - n));
                    lost = 1'b0;
                end
                default: begin
                    r    = d;
                    lost = 1'b0;
                end
            endcase
        end else begin
            r    = d;
            lost = 1'b0;
        end
        return {lost, r};
    endfunction

    logic [SHW-1:0]             valid_q, valid_d;
    logic [SHW-1:0][WIDTH-1:0]  data_q,  data_d;
    logic [SHW-1:0][SHW-1:0]    amt_q,   amt_d;
    logic [SHW-1:0][1:0]        mode_q,  mode_d;
    logic [SHW-1:0]             shout_q, shout_d;

    // Element 0 is the input port, element i+1 is stage register i.
    logic [SHW:0]               chain_valid_s;
    logic [SHW:0][WIDTH-1:0]    chain_data_s;
    logic [SHW:0][SHW-1:0]      chain_amt_s;
    logic [SHW:0][1:0]          chain_mode_s;
    logic [SHW:0]               chain_shout_s;

    logic                       adv_s;
    logic [WIDTH:0]             stage_res_s;
    logic                       unused_s;

    assign chain_valid_s = {valid_q, in_valid};
    assign chain_data_s  = {data_q,  in_data};
    assign chain_amt_s   = {amt_q,   in_amt};
    assign chain_mode_s  = {mode_q,  in_mode};
    assign chain_shout_s = {shout_q, 1'b0};

    // The last stage's amount and mode are not needed once the result is formed.
    assign unused_s = ^{chain_amt_s[SHW], chain_mode_s[SHW]};

    // Whole-pipeline advance/hold and per-stage shift computation.
    always_comb begin
        adv_s       = !valid_q[SHW-1] || out_ready;
        valid_d     = valid_q;
        data_d      = data_q;
        amt_d       = amt_q;
        mode_d      = mode_q;
        shout_d     = shout_q;
        stage_res_s = '0;
        if (adv_s) begin
            for (int i = 0; i < SHW; i++) begin
                stage_res_s = stage_op(chain_data_s[i], chain_mode_s[i],
                                       chain_amt_s[i][i], 32'd1 << i);
                valid_d[i] = chain_valid_s[i];
                data_d[i]  = stage_res_s[WIDTH-1:0];
                amt_d[i]   = chain_amt_s[i];
                mode_d[i]  = chain_mode_s[i];
                shout_d[i] = chain_shout_s[i] | stage_res_s[WIDTH];
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
            amt_d   = amt_q;
            mode_d  = mode_q;
            shout_d = shout_q;
        end
    end

    // Stage registers; reset discards every in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
            shout_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            shout_q <= shout_d;
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_shout = shout_q[SHW-1];

endmodule
